// File: rtl/ram2_ctrl_pkg.sv
// ram2_ctrl shared types: FSM state codes, port owner codes, SRAM pin levels.
// Imported by ram2_ctrl; no logic lives here.
package ram2_ctrl_pkg;

  typedef enum logic [2:0] {
    RAM2_IDLE     = 3'd0,
    RAM2_RD       = 3'd1,
    RAM2_WR_SETUP = 3'd2,
    RAM2_WR_PULSE = 3'd3,
    RAM2_WR_HOLD  = 3'd4,
    RAM2_DONE     = 3'd5
  } ram2_state_e;

  typedef enum logic {
    RAM_PORT_IF  = 1'b0,
    RAM_PORT_MEM = 1'b1
  } ram2_port_e;

  localparam logic RAM_EN  = 1'b0;
  localparam logic RAM_DIS = 1'b1;

  localparam int BUS_ADDR_W = 32;

endpackage

// File: rtl/ram2_ctrl.sv
// RAM2 SRAM controller: MEM-over-IF arbitration, multi-cycle SRAM sequencing.
// Define RAM2_CTRL_POSTED_WR_EN to ack MEM stores before the write runs.
module ram2_ctrl
  import ram2_ctrl_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [BUS_ADDR_W-1:0] if_addr_i,
  output logic                  if_ack_o,
  output logic [DATA_W-1:0]     if_inst_o,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [BUS_ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0]     mem_data_i,
  output logic                  mem_ack_o,
  output logic [DATA_W-1:0]     mem_data_o,
  output logic                  stall_req_o,
  output logic [ADDR_W-1:0]     ram_addr_o,
  output logic [DATA_W-1:0]     ram_data_o,
  output logic                  ram_data_oe_o,
  input  logic [DATA_W-1:0]     ram_data_i,
  output logic                  ram_ce_n_o,
  output logic                  ram_oe_n_o,
  output logic                  ram_we_n_o
);

  ram2_state_e r_state;
  ram2_state_e w_next;
  ram2_port_e  r_owner;
  logic        r_wr;

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_if_inst;
  logic [DATA_W-1:0] r_mem_data;

  logic r_ce_n, r_oe_n, r_we_n, r_doe;
  logic w_ce_n, w_oe_n, w_we_n, w_doe;
  logic w_done, w_if_ack, w_mem_ack;
  logic w_unused;

  // Only the low ADDR_W address bits reach the SRAM.
  assign w_unused = ^{if_addr_i, mem_addr_i};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= RAM2_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      RAM2_IDLE: begin
        if (mem_req_i)
          w_next = mem_we_i ? RAM2_WR_SETUP : RAM2_RD;
        else if (if_req_i)
          w_next = RAM2_RD;
      end
      RAM2_RD:       w_next = RAM2_DONE;
      RAM2_WR_SETUP: w_next = RAM2_WR_PULSE;
      RAM2_WR_PULSE: w_next = RAM2_WR_HOLD;
      RAM2_WR_HOLD:  w_next = RAM2_DONE;
      RAM2_DONE:     w_next = RAM2_IDLE;
      default:       w_next = RAM2_IDLE;
    endcase
  end

  // Pin levels are decoded from the next state so the registered
  // pins line up with the state they belong to.
  always_comb begin
    w_ce_n = RAM_DIS;
    w_oe_n = RAM_DIS;
    w_we_n = RAM_DIS;
    w_doe  = 1'b0;
    unique case (w_next)
      RAM2_RD: begin
        w_ce_n = RAM_EN;
        w_oe_n = RAM_EN;
      end
      RAM2_WR_SETUP, RAM2_WR_HOLD: begin
        w_ce_n = RAM_EN;
        w_doe  = 1'b1;
      end
      RAM2_WR_PULSE: begin
        w_ce_n = RAM_EN;
        w_we_n = RAM_EN;
        w_doe  = 1'b1;
      end
      default: ;
    endcase
    w_done   = (r_state == RAM2_DONE);
    w_if_ack = w_done && (r_owner == RAM_PORT_IF);
`ifdef RAM2_CTRL_POSTED_WR_EN
    w_mem_ack = (r_state == RAM2_WR_SETUP) ||
                (w_done && (r_owner == RAM_PORT_MEM) && !r_wr);
`else
    w_mem_ack = w_done && (r_owner == RAM_PORT_MEM);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ce_n     <= RAM_DIS;
      r_oe_n     <= RAM_DIS;
      r_we_n     <= RAM_DIS;
      r_doe      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_owner    <= RAM_PORT_IF;
      r_wr       <= 1'b0;
      r_if_inst  <= '0;
      r_mem_data <= '0;
    end else begin
      r_ce_n <= w_ce_n;
      r_oe_n <= w_oe_n;
      r_we_n <= w_we_n;
      r_doe  <= w_doe;
      if (r_state == RAM2_IDLE) begin
        priority case (1'b1)
          mem_req_i: begin
            r_addr  <= mem_addr_i[ADDR_W-1:0];
            r_wdata <= mem_data_i;
            r_owner <= RAM_PORT_MEM;
            r_wr    <= mem_we_i;
          end
          if_req_i: begin
            r_addr  <= if_addr_i[ADDR_W-1:0];
            r_owner <= RAM_PORT_IF;
            r_wr    <= 1'b0;
          end
          default: ;
        endcase
      end
      if (r_state == RAM2_RD) begin
        if (r_owner == RAM_PORT_MEM) r_mem_data <= ram_data_i;
        else                         r_if_inst  <= ram_data_i;
      end
    end
  end

  assign if_ack_o      = w_if_ack;
  assign mem_ack_o     = w_mem_ack;
  assign if_inst_o     = r_if_inst;
  assign mem_data_o    = r_mem_data;
  assign ram_addr_o    = r_addr;
  assign ram_data_o    = r_wdata;
  assign ram_data_oe_o = r_doe;
  assign ram_ce_n_o    = r_ce_n;
  assign ram_oe_n_o    = r_oe_n;
  assign ram_we_n_o    = r_we_n;

  assign stall_req_o = (if_req_i  & ~w_if_ack) |
                       (mem_req_i & ~w_mem_ack);

endmodule

// File: tb/tb_ram2_ctrl.sv
// Self-checking bench for ram2_ctrl: SRAM model plus a word-array reference
// model with latencies derived from the access rules.
module tb_ram2_ctrl;

  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;
`ifdef RAM2_CTRL_POSTED_WR_EN
  localparam int WR_LAT = 1;
`else
  localparam int WR_LAT = 4;
`endif
  localparam int RD_LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_i, mem_req_i, mem_we_i;
  logic [31:0]   if_addr_i, mem_addr_i;
  logic [DW-1:0] mem_data_i;
  logic          if_ack_o, mem_ack_o, stall_req_o;
  logic [DW-1:0] if_inst_o, mem_data_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_data_o, ram_data_i;
  logic          ram_data_oe_o, ram_ce_n_o, ram_oe_n_o, ram_we_n_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram2_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_ack_o(if_ack_o), .if_inst_o(if_inst_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
    .mem_ack_o(mem_ack_o), .mem_data_o(mem_data_o),
    .stall_req_o(stall_req_o),
    .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
    .ram_data_oe_o(ram_data_oe_o), .ram_data_i(ram_data_i),
    .ram_ce_n_o(ram_ce_n_o), .ram_oe_n_o(ram_oe_n_o),
    .ram_we_n_o(ram_we_n_o)
  );

  function automatic logic [31:0] init_word(input int a);
    logic [31:0] v;
    v = 32'(a);
    if (a == 16) return 32'h3C011234;
    return (v * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  function automatic int idx(input logic [31:0] a);
    return int'(a % 32'(DEPTH));
  endfunction

  // SRAM model: unwritten words read back their initial pattern.
  logic [DW-1:0] sram [DEPTH];
  bit            wr_v [DEPTH];
  always @(posedge clk)
    if (rst && !ram_ce_n_o && !ram_we_n_o && ram_data_oe_o) begin
      sram[ram_addr_o] <= ram_data_o;
      wr_v[ram_addr_o] <= 1'b1;
    end
  assign ram_data_i = (!ram_ce_n_o && !ram_oe_n_o) ?
    (wr_v[ram_addr_o] ? sram[ram_addr_o] : init_word(int'(ram_addr_o))) :
    32'hBAD0BAD0;

  logic [31:0] ref_mem [DEPTH];

  typedef struct {
    int          lat;
    logic [31:0] rdata;
    int          we_low;
    int          oe_low;
    int          oe_first;
    logic [AW-1:0] raddr;
    logic [AW-1:0] waddr;
    logic [31:0] wdata;
    logic [31:0] stall;
    bit          bad;
    bit          timeout;
  } obs_t;

  // Runs one access from IDLE and returns what the pins and port did.
  task automatic access(input bit is_mem, input bit we,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output obs_t o);
    bit acked;
    o = '{lat: 0, rdata: 0, we_low: 0, oe_low: 0, oe_first: 0,
          raddr: 0, waddr: 0, wdata: 0, stall: 0, bad: 0, timeout: 0};
    if (is_mem) begin
      mem_we_i = we; mem_addr_i = addr; mem_data_i = wd; mem_req_i = 1'b1;
    end else begin
      if_addr_i = addr; if_req_i = 1'b1;
    end
    #1 o.stall[0] = stall_req_o;
    acked = 1'b0;
    for (int c = 1; c <= 20 && !acked; c++) begin
      @(posedge clk); #1;
      o.stall[c] = stall_req_o;
      if (ram_we_n_o === 1'b0) begin
        o.we_low++; o.waddr = ram_addr_o; o.wdata = ram_data_o;
      end
      if (ram_oe_n_o === 1'b0) begin
        if (o.oe_low == 0) begin o.oe_first = c; o.raddr = ram_addr_o; end
        o.oe_low++;
      end
      if (!ram_oe_n_o && (!ram_we_n_o || ram_data_oe_o)) o.bad = 1'b1;
      if ((is_mem ? mem_ack_o : if_ack_o) === 1'b1) begin
        acked = 1'b1; o.lat = c;
        o.rdata = is_mem ? mem_data_o : if_inst_o;
      end
    end
    o.timeout = !acked;
    mem_req_i = 1'b0; if_req_i = 1'b0;
    mem_addr_i = $urandom; mem_data_i = $urandom; if_addr_i = $urandom;
    if (acked && is_mem && we && o.lat == 1) begin
      for (int c = 2; c <= 4; c++) begin
        @(posedge clk); #1;
        if (ram_we_n_o === 1'b0) begin
          o.we_low++; o.waddr = ram_addr_o; o.wdata = ram_data_o;
        end
        if (!ram_oe_n_o && (!ram_we_n_o || ram_data_oe_o)) o.bad = 1'b1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (4) begin
      if_req_i = 1'($urandom); mem_req_i = 1'($urandom);
      mem_we_i = 1'($urandom); if_addr_i = $urandom;
      mem_addr_i = $urandom; mem_data_i = $urandom;
      @(posedge clk); #1;
    end
    checks += 9;
    if (ram_ce_n_o !== 1'b1) begin errors++;
      $display("FAIL reset_ce_n: got %b expected 1", ram_ce_n_o); end
    if (ram_oe_n_o !== 1'b1) begin errors++;
      $display("FAIL reset_oe_n: got %b expected 1", ram_oe_n_o); end
    if (ram_we_n_o !== 1'b1) begin errors++;
      $display("FAIL reset_we_n: got %b expected 1", ram_we_n_o); end
    if (ram_data_oe_o !== 1'b0) begin errors++;
      $display("FAIL reset_data_oe: got %b expected 0", ram_data_oe_o); end
    if ({if_ack_o, mem_ack_o} !== 2'b00) begin errors++;
      $display("FAIL reset_acks: got %b expected 00", {if_ack_o, mem_ack_o}); end
    if (if_inst_o !== 32'h0) begin errors++;
      $display("FAIL reset_if_inst: got %h expected 0", if_inst_o); end
    if (mem_data_o !== 32'h0) begin errors++;
      $display("FAIL reset_mem_data: got %h expected 0", mem_data_o); end
    if (ram_addr_o !== '0) begin errors++;
      $display("FAIL reset_addr: got %h expected 0", ram_addr_o); end
    if (ram_data_o !== '0) begin errors++;
      $display("FAIL reset_wdata: got %h expected 0", ram_data_o); end
    if_req_i = 1'b0; mem_req_i = 1'b0; mem_we_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_if_read();
    obs_t o;
    access(1'b0, 1'b0, 32'h10, 32'h0, o);
    checks += 6;
    if (o.lat !== RD_LAT) begin errors++;
      $display("FAIL if_read_lat: got %0d expected %0d", o.lat, RD_LAT); end
    if (o.rdata !== 32'h3C011234) begin errors++;
      $display("FAIL if_read_data: got %h expected 3c011234", o.rdata); end
    if (o.oe_first !== 1 || o.oe_low !== 1) begin errors++;
      $display("FAIL if_read_oe: got first %0d count %0d expected 1 1",
               o.oe_first, o.oe_low); end
    if (o.stall[2:0] !== 3'b011) begin errors++;
      $display("FAIL if_read_stall: got %b expected 011", o.stall[2:0]); end
    if (o.raddr !== 12'h010) begin errors++;
      $display("FAIL if_read_addr: got %h expected 010", o.raddr); end
    if (o.bad) begin errors++;
      $display("FAIL if_read_pins: got overlap 1 expected 0"); end
  endtask

  task automatic test_contention();
    int ml, il;
    logic [31:0] md, id;
    ml = 0; il = 0; md = 0; id = 0;
    mem_we_i = 1'b0; mem_addr_i = 32'h8; if_addr_i = 32'h4;
    mem_req_i = 1'b1; if_req_i = 1'b1;
    for (int c = 1; c <= 15 && (ml == 0 || il == 0); c++) begin
      @(posedge clk); #1;
      if (ml == 0 && mem_ack_o) begin ml = c; md = mem_data_o; mem_req_i = 1'b0; end
      if (il == 0 && if_ack_o) begin il = c; id = if_inst_o; if_req_i = 1'b0; end
    end
    mem_req_i = 1'b0; if_req_i = 1'b0;
    @(posedge clk); #1;
    checks += 4;
    if (ml !== 2) begin errors++;
      $display("FAIL contention_mem_lat: got %0d expected 2", ml); end
    if (il !== 5) begin errors++;
      $display("FAIL contention_if_lat: got %0d expected 5", il); end
    if (md !== ref_mem[8]) begin errors++;
      $display("FAIL contention_mem_data: got %h expected %h", md, ref_mem[8]); end
    if (id !== ref_mem[4]) begin errors++;
      $display("FAIL contention_if_data: got %h expected %h", id, ref_mem[4]); end
  endtask

  task automatic test_store();
    obs_t o;
    access(1'b1, 1'b1, 32'h0FFF, 32'hDEADBEEF, o);
    ref_mem[12'hFFF] = 32'hDEADBEEF;
    checks += 5;
    if (o.lat !== WR_LAT) begin errors++;
      $display("FAIL store_lat: got %0d expected %0d", o.lat, WR_LAT); end
    if (o.we_low !== 1) begin errors++;
      $display("FAIL store_we_pulse: got %0d cycles expected 1", o.we_low); end
    if (o.waddr !== 12'hFFF) begin errors++;
      $display("FAIL store_addr: got %h expected fff", o.waddr); end
    if (o.wdata !== 32'hDEADBEEF) begin errors++;
      $display("FAIL store_data: got %h expected deadbeef", o.wdata); end
    if (o.bad) begin errors++;
      $display("FAIL store_pins: got overlap 1 expected 0"); end
    access(1'b1, 1'b0, 32'h0FFF, 32'h0, o);
    checks += 2;
    if (o.rdata !== 32'hDEADBEEF) begin errors++;
      $display("FAIL store_readback: got %h expected deadbeef", o.rdata); end
    if (o.lat !== RD_LAT) begin errors++;
      $display("FAIL store_readback_lat: got %0d expected %0d", o.lat, RD_LAT); end
  endtask

  task automatic test_wrap();
    obs_t o;
    access(1'b1, 1'b0, 32'h0000_1000, 32'h0, o);
    checks += 2;
    if (o.raddr !== 12'h000) begin errors++;
      $display("FAIL wrap_addr: got %h expected 000", o.raddr); end
    if (o.rdata !== ref_mem[0]) begin errors++;
      $display("FAIL wrap_data: got %h expected %h", o.rdata, ref_mem[0]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [4];
    logic [31:0] d [4];
    int t [4];
    int n;
    foreach (a[i]) begin a[i] = $urandom; d[i] = 0; t[i] = 0; end
    n = 0; if_addr_i = a[0]; if_req_i = 1'b1;
    for (int c = 1; c <= 30 && n < 4; c++) begin
      @(posedge clk); #1;
      if (if_ack_o) begin
        t[n] = c; d[n] = if_inst_o; n++;
        if (n < 4) if_addr_i = a[n];
        else if_req_i = 1'b0;
      end
    end
    if_req_i = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      checks += 2;
      if (t[i] !== RD_LAT + 3 * i) begin errors++;
        $display("FAIL b2b_time[%0d]: got %0d expected %0d", i, t[i], RD_LAT + 3 * i); end
      if (d[i] !== ref_mem[idx(a[i])]) begin errors++;
        $display("FAIL b2b_data[%0d]: got %h expected %h", i, d[i], ref_mem[idx(a[i])]); end
    end
  endtask

  task automatic test_random();
    obs_t o;
    bit is_mem, we;
    logic [31:0] a, wd;
    int exp_lat;
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      is_mem = 1'($urandom);
      we = is_mem && ($urandom_range(0, 2) == 0);
      a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) a = a | 32'h0000_0FE0;
      wd = $urandom;
      exp_lat = we ? WR_LAT : RD_LAT;
      access(is_mem, we, a, wd, o);
      checks += 3;
      if (o.timeout || o.lat !== exp_lat) begin errors++;
        $display("FAIL rand_lat[%0d]: got %0d expected %0d", i, o.lat, exp_lat); end
      if (o.bad) begin errors++;
        $display("FAIL rand_pins[%0d]: got overlap 1 expected 0", i); end
      if (we) begin
        ref_mem[idx(a)] = wd;
        if (o.we_low !== 1 || o.waddr !== AW'(idx(a)) || o.wdata !== wd) begin
          errors++;
          $display("FAIL rand_write[%0d]: got %0d@%h=%h expected 1@%h=%h",
                   i, o.we_low, o.waddr, o.wdata, AW'(idx(a)), wd);
        end
      end else begin
        if (o.rdata !== ref_mem[idx(a)] || o.oe_low !== 1) begin errors++;
          $display("FAIL rand_read[%0d]: got %h (oe %0d) expected %h (oe 1)",
                   i, o.rdata, o.oe_low, ref_mem[idx(a)]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_write();
    obs_t o;
    logic [31:0] wd;
    mem_we_i = 1'b1; mem_addr_i = 32'h123; mem_data_i = $urandom; mem_req_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks += 1;
    if (ram_we_n_o !== 1'b0) begin errors++;
      $display("FAIL midrst_pulse: got we_n %b expected 0", ram_we_n_o); end
    #2 rst = 1'b0;
    #1;
    checks += 3;
    if (ram_we_n_o !== 1'b1) begin errors++;
      $display("FAIL midrst_we_n: got %b expected 1", ram_we_n_o); end
    if (ram_ce_n_o !== 1'b1 || ram_data_oe_o !== 1'b0) begin errors++;
      $display("FAIL midrst_pins: got ce_n %b oe %b expected 1 0",
               ram_ce_n_o, ram_data_oe_o); end
    if (mem_ack_o !== 1'b0) begin errors++;
      $display("FAIL midrst_ack: got %b expected 0", mem_ack_o); end
    mem_req_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks += 2;
    if (mem_ack_o !== 1'b0 || if_ack_o !== 1'b0) begin errors++;
      $display("FAIL midrst_no_ack: got %b%b expected 00", mem_ack_o, if_ack_o); end
    if (mem_data_o !== 32'h0 || if_inst_o !== 32'h0) begin errors++;
      $display("FAIL midrst_zero: got %h %h expected 0 0", mem_data_o, if_inst_o); end
    access(1'b1, 1'b0, 32'h0456, 32'h0, o);
    checks += 2;
    if (o.lat !== RD_LAT) begin errors++;
      $display("FAIL midrst_idle: got lat %0d expected %0d", o.lat, RD_LAT); end
    if (o.rdata !== ref_mem[12'h456]) begin errors++;
      $display("FAIL midrst_read: got %h expected %h", o.rdata, ref_mem[12'h456]); end
    wd = $urandom;
    access(1'b1, 1'b1, 32'h123, wd, o);
    ref_mem[12'h123] = wd;
    access(1'b0, 1'b0, 32'h123, 32'h0, o);
    checks += 1;
    if (o.rdata !== wd) begin errors++;
      $display("FAIL midrst_restore: got %h expected %h", o.rdata, wd); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    if_req_i = 1'b0; mem_req_i = 1'b0; mem_we_i = 1'b0;
    if_addr_i = 0; mem_addr_i = 0; mem_data_i = 0;
    rst = 1'b0;
    #1;
    test_reset();
    test_if_read();
    test_contention();
    test_store();
    test_wrap();
    test_back_to_back();
    test_random();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
